// File: rtl/prog_melody_gen_mc_if.sv
// Bus bundle for the multi-channel melody generator: programming inputs, voice outputs.
`timescale 1ns/1ps
interface prog_melody_gen_mc_if #(
  parameter int CHANNELS = 2
);
  logic                restart;
  logic                reload;
  logic                pgm_strobe;
  logic                pgm_data;
  logic [CHANNELS-1:0] mel;
  logic                pgm_err;
  logic                mix;

  modport master (
    output restart, reload, pgm_strobe, pgm_data,
    input  mel, pgm_err, mix
  );

  modport slave (
    input  restart, reload, pgm_strobe, pgm_data,
    output mel, pgm_err, mix
  );
endinterface

// File: rtl/prog_melody_gen_mc.sv
// Multi-channel programmable square-wave melody generator with serial note programming.
// Define MIX_EN to enable the sigma-delta mixer on mix; otherwise mix is tied low.
`timescale 1ns/1ps
module prog_melody_gen_mc #(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 16,
  parameter int PITCH_W  = 8,
  parameter int DUR_W    = 4,
  parameter int TICK_DIV = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prog_melody_gen_mc_if.slave  bus
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NW  = DUR_W + PITCH_W;
  localparam int F   = CW + AW + NW;
  localparam int BCW = $clog2(F + 1);
  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MW  = 1 << (CW + AW);

  typedef enum logic [1:0] {S_LOAD, S_PLAY, S_IDLE} state_t;

  logic            r_strobe_q, r_reload_q, r_err;
  logic [F-1:0]    r_shift;
  logic [BCW-1:0]  r_bits;
  logic [NW-1:0]   r_mem [MW];
  logic [TW-1:0]   r_tick_cnt;

  logic            w_strobe_rise, w_reload_rise, w_full, w_commit, w_tick;
  logic [CW-1:0]   w_chan;
  logic [AW-1:0]   w_addr;
  logic [NW-1:0]   w_word;
  logic [CHANNELS-1:0] w_mel;

  assign w_strobe_rise = bus.pgm_strobe & ~r_strobe_q;
  assign w_reload_rise = bus.reload & ~r_reload_q;
  assign w_full        = (r_bits == BCW'(F));
  assign {w_chan, w_addr, w_word} = r_shift;
  assign w_commit      = w_reload_rise & w_full & (32'(w_chan) < 32'(CHANNELS));
  assign w_tick        = (r_tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_strobe_q <= 1'b0;
      r_reload_q <= 1'b0;
      r_bits     <= '0;
      r_err      <= 1'b0;
      r_tick_cnt <= '0;
    end else begin
      r_strobe_q <= bus.pgm_strobe;
      r_reload_q <= bus.reload;
      if (w_reload_rise)
        r_bits <= '0;
      else if (w_strobe_rise && !w_full)
        r_bits <= r_bits + BCW'(1);
      // A short frame outranks a simultaneous restart so the error is never lost.
      if (w_reload_rise && !w_full)
        r_err <= 1'b1;
      else if (bus.restart)
        r_err <= 1'b0;
      if (bus.restart || w_tick)
        r_tick_cnt <= '0;
      else
        r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_strobe_rise)
      r_shift <= {r_shift[F-2:0], bus.pgm_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MW; i++)
        r_mem[i] <= '0;
    end else if (w_commit) begin
      r_mem[{w_chan, w_addr}] <= w_word;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t              r_state, w_state_nx;
    logic [AW-1:0]       r_addr, w_addr_nx;
    logic [PITCH_W-1:0]  r_pitch, w_pitch_nx, r_tone, w_tone_nx, w_rd_pitch;
    logic [DUR_W-1:0]    r_dur, w_dur_nx, w_rd_dur;
    logic                r_mel, w_mel_nx, w_wr_here;

    assign {w_rd_dur, w_rd_pitch} = r_mem[{CW'(g), r_addr}];
    assign w_wr_here = w_commit & (w_chan == CW'(g));
    assign w_mel[g]  = r_mel;

    always_comb begin
      w_state_nx = r_state;
      w_addr_nx  = r_addr;
      w_pitch_nx = r_pitch;
      w_tone_nx  = r_tone;
      w_dur_nx   = r_dur;
      w_mel_nx   = r_mel;
      if (bus.restart) begin
        w_state_nx = S_LOAD;
        w_addr_nx  = '0;
        w_mel_nx   = 1'b0;
      end else begin
        case (r_state)
          S_LOAD: begin
            w_mel_nx = 1'b0;
            if (w_rd_dur == '0) begin
              w_addr_nx = '0;
              if (r_addr == '0)
                w_state_nx = S_IDLE;
            end else begin
              w_state_nx = S_PLAY;
              w_pitch_nx = w_rd_pitch;
              w_tone_nx  = w_rd_pitch;
              w_dur_nx   = w_rd_dur;
            end
          end
          S_PLAY: begin
            if (r_pitch == '0) begin
              w_mel_nx = 1'b0;
            end else if (r_tone == PITCH_W'(1)) begin
              w_tone_nx = r_pitch;
              w_mel_nx  = ~r_mel;
            end else begin
              w_tone_nx = r_tone - PITCH_W'(1);
            end
            if (w_tick) begin
              w_dur_nx = r_dur - DUR_W'(1);
              if (r_dur == DUR_W'(1)) begin
                w_state_nx = S_LOAD;
                w_addr_nx  = r_addr + AW'(1);
                w_mel_nx   = 1'b0;
              end
            end
          end
          S_IDLE: begin
            w_mel_nx = 1'b0;
            if (w_wr_here) begin
              w_state_nx = S_LOAD;
              w_addr_nx  = '0;
            end
          end
          default: w_state_nx = S_LOAD;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= S_LOAD;
        r_addr  <= '0;
        r_mel   <= 1'b0;
      end else begin
        r_state <= w_state_nx;
        r_addr  <= w_addr_nx;
        r_mel   <= w_mel_nx;
      end
    end

    always_ff @(posedge clk) begin
      r_pitch <= w_pitch_nx;
      r_tone  <= w_tone_nx;
      r_dur   <= w_dur_nx;
    end
  end

  assign bus.mel     = w_mel;
  assign bus.pgm_err = r_err;

`ifdef MIX_EN
  localparam int SW = $clog2(2 * CHANNELS);
  logic [SW-1:0] r_acc, w_sum;
  logic          r_mix;

  always_comb begin
    w_sum = r_acc;
    for (int i = 0; i < CHANNELS; i++)
      w_sum = w_sum + SW'(w_mel[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_mix <= 1'b0;
    end else if (w_sum >= SW'(CHANNELS)) begin
      r_mix <= 1'b1;
      r_acc <= w_sum - SW'(CHANNELS);
    end else begin
      r_mix <= 1'b0;
      r_acc <= w_sum;
    end
  end

  assign bus.mix = r_mix;
`else
  assign bus.mix = 1'b0;
`endif
endmodule
